// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage controller.
package mem_stage_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_REG_W  = 4;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef struct packed {
    logic                 RegWrite;
    logic                 MemToReg;
    logic [WB_DATA_W-1:0] data;
    logic [WB_REG_W-1:0]  rr;
  } wb_bundle_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack bus between the MEM-stage controller and data memory.
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_timeout_cnt.sv
// Access watchdog: counts cycles while enabled, flags TIMEOUT-1 reached.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_hit
);
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory accesses, stalls upstream while
// one is outstanding, and registers the write-back result.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int REG_W   = WB_REG_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemToReg_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              RegWrite_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] RD3_in,
  input  logic [REG_W-1:0]  RR3_in,
  output logic              stall,
  mem_stage_ctrl_if.master  mem,
  output logic              wb_valid,
  output logic              RegWrite_out,
  output logic              MemToReg_out,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  RR3_out,
  output logic              err
);
  state_t            r_state, w_state_nxt;
  wb_bundle_t        r_wb, w_wb_nxt;
  wb_bundle_t        r_lat, w_lat_nxt;
  logic              r_wb_valid, w_wb_valid_nxt;
  logic              r_err, w_err_nxt;
  logic              r_req, w_req_nxt;
  logic              r_we, w_we_nxt;
  logic [DATA_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              w_cnt_clr, w_cnt_en, w_hit;
  logic              w_memop, w_misal;

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_hit   (w_hit)
  );

  assign w_memop = MemRead_in | MemWrite_in;
  assign w_misal = is_misaligned(alu_in[1:0]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wb_nxt       = r_wb;
    w_lat_nxt      = r_lat;
    w_wb_valid_nxt = 1'b0;
    w_err_nxt      = r_err;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_cnt_clr      = 1'b1;
    w_cnt_en       = 1'b0;
    stall          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_memop) begin
          w_wb_valid_nxt    = 1'b1;
          w_wb_nxt.RegWrite = RegWrite_in;
          w_wb_nxt.MemToReg = MemToReg_in;
          w_wb_nxt.data     = alu_in;
          w_wb_nxt.rr       = RR3_in;
        end else if (w_misal) begin
          w_wb_valid_nxt    = 1'b1;
          w_wb_nxt.RegWrite = 1'b0;
          w_wb_nxt.MemToReg = MemToReg_in;
          w_wb_nxt.data     = '0;
          w_wb_nxt.rr       = RR3_in;
          w_err_nxt         = 1'b1;
        end else begin
          // Load+store together is flagged but still issued as a store.
          stall              = 1'b1;
          w_req_nxt          = 1'b1;
          w_we_nxt           = MemWrite_in;
          w_addr_nxt         = {alu_in[DATA_W-1:2], 2'b00};
          w_wdata_nxt        = RD3_in;
          w_lat_nxt.RegWrite = RegWrite_in;
          w_lat_nxt.MemToReg = MemToReg_in;
          w_lat_nxt.data     = alu_in;
          w_lat_nxt.rr       = RR3_in;
          if (MemRead_in && MemWrite_in) w_err_nxt = 1'b1;
          w_state_nxt        = ACCESS;
        end
      end
      ACCESS: begin
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b1;
        stall     = !(mem.mem_ack || w_hit);
        if (mem.mem_ack) begin
          w_req_nxt      = 1'b0;
          w_wb_valid_nxt = 1'b1;
          w_wb_nxt       = r_lat;
          w_wb_nxt.data  = r_lat.MemToReg ? mem.mem_rdata : r_lat.data;
          w_state_nxt    = IDLE;
        end else if (w_hit) begin
          w_req_nxt         = 1'b0;
          w_wb_valid_nxt    = 1'b1;
          w_wb_nxt          = r_lat;
          w_wb_nxt.RegWrite = 1'b0;
          w_wb_nxt.data     = '0;
          w_err_nxt         = 1'b1;
          w_state_nxt       = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb       <= '0;
      r_lat      <= '0;
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_wb       <= w_wb_nxt;
      r_lat      <= w_lat_nxt;
      r_wb_valid <= w_wb_valid_nxt;
      r_err      <= w_err_nxt;
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign wb_valid      = r_wb_valid;
  assign RegWrite_out  = r_wb.RegWrite;
  assign MemToReg_out  = r_wb.MemToReg;
  assign wb_data       = r_wb.data;
  assign RR3_out       = r_wb.rr;
  assign err           = r_err;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected write-backs queued at issue,
// compared whenever the DUT pulses wb_valid.
module tb_mem_stage_ctrl;
  localparam int TMO = 16;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [31:0] data;
    logic [3:0]  rr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in;
  logic [31:0] alu_in, RD3_in;
  logic [3:0]  RR3_in;
  logic        stall, wb_valid, RegWrite_out, MemToReg_out, err;
  logic [31:0] wb_data;
  logic [3:0]  RR3_out;

  exp_t exp_q[$];
  logic exp_err;
  int   n_vec  = 0;
  int   n_miss = 0;

  mem_stage_ctrl_if #(.DATA_W(32)) mif ();

  mem_stage_ctrl #(.DATA_W(32), .REG_W(4), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemToReg_in  (MemToReg_in),
    .MemRead_in   (MemRead_in),
    .MemWrite_in  (MemWrite_in),
    .RegWrite_in  (RegWrite_in),
    .alu_in       (alu_in),
    .RD3_in       (RD3_in),
    .RR3_in       (RR3_in),
    .stall        (stall),
    .mem          (mif.master),
    .wb_valid     (wb_valid),
    .RegWrite_out (RegWrite_out),
    .MemToReg_out (MemToReg_out),
    .wb_data      (wb_data),
    .RR3_out      (RR3_out),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 64'(wb_valid), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_bundle", 64'({RegWrite_out, MemToReg_out, wb_data, RR3_out}), 64'(e));
      end
    end
  end

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    {MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in} = '0;
    alu_in = '0; RD3_in = '0; RR3_in = '0;
    exp_q.delete();
    exp_err = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_req", 64'(mif.mem_req), 64'(0));
    chk("rst_we", 64'(mif.mem_we), 64'(0));
    chk("rst_addr", 64'(mif.mem_addr), 64'(0));
    chk("rst_wdata", 64'(mif.mem_wdata), 64'(0));
    chk("rst_wbv", 64'(wb_valid), 64'(0));
    chk("rst_wb", 64'({RegWrite_out, MemToReg_out, wb_data, RR3_out}), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    rst = 1'b0;
  endtask

  // ack_dly = 0 means memory never answers.
  task automatic run_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                        input logic [31:0] alu, input logic [31:0] rd3, input logic [3:0] rr,
                        input int ack_dly, input logic [31:0] rdata);
    logic memop, misal, tmo, acked;
    exp_t e;
    memop = rd | wr;
    misal = alu[1:0] != 2'b00;
    tmo   = (ack_dly == 0) || (ack_dly > TMO);
    MemRead_in = rd; MemWrite_in = wr; RegWrite_in = rw; MemToReg_in = m2r;
    alu_in = alu; RD3_in = rd3; RR3_in = rr;
    if (!memop)               e = '{rw, m2r, alu, rr};
    else if (misal || tmo)    e = '{1'b0, m2r, 32'h0, rr};
    else                      e = '{rw, m2r, (m2r ? rdata : alu), rr};
    if (memop && (misal || tmo || (rd && wr))) exp_err = 1'b1;
    exp_q.push_back(e);
    #1 chk("stall_idle", 64'(stall), 64'(memop && !misal));
    @(posedge clk); #1;
    if (memop && !misal) begin
      for (int k = 1; k <= TMO; k++) begin
        chk("acc_req", 64'(mif.mem_req), 64'(1));
        chk("acc_addr", 64'(mif.mem_addr), 64'(alu));
        chk("acc_we", 64'(mif.mem_we), 64'(wr));
        chk("acc_wdata", 64'(mif.mem_wdata), 64'(rd3));
        chk("acc_wbv", 64'(wb_valid), 64'(0));
        acked = !tmo && (k == ack_dly);
        if (acked) begin
          mif.mem_ack = 1'b1;
          mif.mem_rdata = rdata;
        end
        #1 chk("stall_acc", 64'(stall), 64'(!(acked || k == TMO)));
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        if (acked || k == TMO) break;
      end
    end
    chk("ret_wbv", 64'(wb_valid), 64'(1));
    chk("ret_req", 64'(mif.mem_req), 64'(0));
    chk("ret_err", 64'(err), 64'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    do_reset(2);
    run_op(0, 0, 1, 0, 32'h1234, 32'h0, 4'd5, 0, 32'h0);
    run_op(1, 0, 1, 1, 32'h40, 32'h0, 4'd2, 3, 32'hDEADBEEF);
    run_op(0, 1, 0, 0, 32'h80, 32'hCAFE, 4'd0, 1, 32'h0);
    run_op(1, 0, 1, 1, 32'h44, 32'h77, 4'd9, 2, 32'h12345678);
    run_op(1, 0, 1, 1, 32'h42, 32'h0, 4'd7, 0, 32'h0);
    run_op(1, 0, 1, 1, 32'hC0, 32'h0, 4'd6, 0, 32'h0);
    run_op(0, 0, 1, 0, 32'hABCD0000, 32'h0, 4'd1, 0, 32'h0);

    // Abort an outstanding load with reset, then ack late while idle.
    MemRead_in = 1'b1; MemWrite_in = 1'b0; RegWrite_in = 1'b1; MemToReg_in = 1'b1;
    alu_in = 32'h100; RD3_in = 32'h0; RR3_in = 4'd4;
    @(posedge clk); #1;
    chk("abort_req", 64'(mif.mem_req), 64'(1));
    @(posedge clk); #1;
    do_reset(1);
    mif.mem_ack = 1'b1;
    mif.mem_rdata = 32'h5555;
    run_op(0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 0, 32'h0);
    mif.mem_ack = 1'b0;

    run_op(1, 1, 1, 0, 32'h10, 32'hAA, 4'd3, 2, 32'h0);
    run_op(1, 0, 1, 1, 32'h20, 32'h0, 4'd8, 20, 32'hFFFF);
    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller that consumes the EX/MEM pipeline register outputs.
- Performs loads/stores to data memory over a req/ack handshake and stalls the upstream pipeline while an access is outstanding.
- Drives the registered MEM/WB-side result: write-back data, destination register and control.
- Sits between segment_ex_mem and the MEM/WB segment / data memory.

Parameters:
DATA_W, 32, data and address width
REG_W, 4, destination register index width
TIMEOUT, 16, max cycles waiting for mem_ack before abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
MemToReg_in  in  1  write-back selects memory data
MemRead_in  in  1  load request
MemWrite_in  in  1  store request
RegWrite_in  in  1  instruction writes register file
alu_in  in  DATA_W  ALU result / memory byte address
RD3_in  in  DATA_W  store data
RR3_in  in  REG_W  destination register
stall  out  1  hold EX/MEM and earlier stages (combinational)
mem_req  out  1  memory request, held until ack
mem_we  out  1  1=store, 0=load
mem_addr  out  DATA_W  word-aligned address
mem_wdata  out  DATA_W  store data
mem_ack  in  1  single-cycle completion; mem_rdata valid with it
mem_rdata  in  DATA_W  load data
wb_valid  out  1  one-cycle pulse per retired instruction
RegWrite_out  out  1  registered RegWrite
MemToReg_out  out  1  registered MemToReg
wb_data  out  DATA_W  mem_rdata if load, else alu_in
RR3_out  out  REG_W  registered destination
err  out  1  sticky error flag, cleared only by rst

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset: FSM=IDLE; all outputs are 0 (mem_req, mem_we, mem_addr, mem_wdata, wb_valid, RegWrite_out, MemToReg_out, wb_data, RR3_out, err). Timeout counter is 0. Reset overrides an outstanding access; a later mem_ack is ignored.
- FSM states: IDLE, ACCESS.
- IDLE with no memory op (MemRead_in=MemWrite_in=0):
  - stall=0.
  - Next edge registers outputs: wb_valid=1, wb_data=alu_in, RegWrite/MemToReg/RR3 copied.
  - Latency is 1 cycle.
- IDLE with a memory op and alu_in[1:0]==0:
  - stall=1.
  - Next edge latches addr, data and controls; sets mem_req=1 and mem_we=MemWrite_in; goes to ACCESS; wb_valid=0.
- IDLE with a memory op and alu_in[1:0]!=0 (misaligned):
  - No memory access and stall=0.
  - Next edge retires the instruction with wb_valid=1, RegWrite_out=0, wb_data=0, and sets err.
- MemRead_in and MemWrite_in both high: treated as a store, err set, access proceeds.
- ACCESS:
  - mem_req, mem_addr and mem_wdata are held stable.
  - stall = !(mem_ack || timeout_hit).
  - Counter increments every cycle in ACCESS.
- ACCESS with mem_ack:
  - Next edge: mem_req=0, wb_valid=1, wb_data = MemToReg ? mem_rdata : latched alu value; return to IDLE.
  - Upstream advances on the same edge.
- ACCESS timeout (counter reaches TIMEOUT-1 without ack):
  - Same retire as ack, but with wb_data=0, RegWrite_out=0, err=1.
- mem_ack while in IDLE: ignored.
- Access latency: 1 + N cycles, where N = cycles from mem_req high to mem_ack (N>=1).
- wb_valid=0 on every stall cycle, so the MEM/WB stage receives bubbles.

Decomposition:
- Package mem_stage_pkg:
  - state_t enum {IDLE, ACCESS}
  - localparam ALIGN_MASK = 2'b11
  - typedef wb_bundle_t struct (RegWrite, MemToReg, data, rr)
- Sub-module mem_timeout_cnt: clear/enable/hit, parameter TIMEOUT.

Test Plan:
- Reset then ALU op (alu_in=0x1234, RegWrite=1, RR3=5) -> next cycle wb_valid=1, wb_data=0x1234, RR3_out=5; stall never asserted.
- Load alu_in=0x40, ack after 3 cycles with rdata=0xDEADBEEF -> mem_req high 3 cycles with addr 0x40, mem_we=0; stall high 3 cycles; wb_data=0xDEADBEEF.
- Store alu_in=0x80, RD3=0xCAFE, ack after 1 cycle -> mem_we=1, mem_wdata=0xCAFE; wb_valid pulses with RegWrite_out=0.
- Load alu_in=0x42 (misaligned) -> mem_req stays 0, stall 0, err=1, wb_data=0.
- Load with no ack, TIMEOUT=16 -> mem_req high 16 cycles, then retire with err=1 and stall released.
- rst asserted mid-ACCESS, then mem_ack -> all outputs 0, FSM IDLE, no wb_valid pulse.
